// File: rtl/vram_rect_fill_if.sv
`default_nettype none
// ============================================================================
// Module   : vram_rect_fill_if
// Brief    : Fill-command handshake, vblank input, VRAM port-B write bus and
//            status flags of the rectangle-fill engine.
// Revision : 1.0  initial release
// ============================================================================
interface vram_rect_fill_if #(
  parameter int AW = 15,
  parameter int XW = 8,
  parameter int YW = 8,
  parameter int CW = 12
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [XW-1:0] cmd_x0;
  logic [YW-1:0] cmd_y0;
  logic [XW-1:0] cmd_x1;
  logic [YW-1:0] cmd_y1;
  logic [CW-1:0] cmd_color;
  logic          vblank;
  logic          we;
  logic [AW-1:0] waddr;
  logic [CW-1:0] wdata;
  logic          busy;
  logic          done;
  logic          err;

  // Driver side: issues commands and supplies the blanking indication.
  modport master (
    output cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color, vblank,
    input  cmd_ready, we, waddr, wdata, busy, done, err
  );

  // Engine side.
  modport slave (
    input  cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color, vblank,
    output cmd_ready, we, waddr, wdata, busy, done, err
  );
endinterface
`default_nettype wire

// File: rtl/vram_rect_fill.sv
`default_nettype none
// ============================================================================
// Module   : vram_rect_fill
// Brief    : Rectangle-fill engine writing one pixel per clock into the
//            frame buffer through VRAM port B, optionally gated on vblank.
// Revision : 1.0  initial release
// ============================================================================
module vram_rect_fill #(
  parameter int H_RES       = 200,
  parameter int V_RES       = 150,
  parameter int AW          = 15,
  parameter int XW          = 8,
  parameter int YW          = 8,
  parameter int CW          = 12,
  parameter bit SYNC_VBLANK = 1'b1
) (
  input  wire logic        pclk,
  input  wire logic        rst,
  vram_rect_fill_if.slave  bus
);

  localparam logic [XW-1:0] C_X_LAST = XW'(H_RES - 1);
  localparam logic [YW-1:0] C_Y_LAST = YW'(V_RES - 1);
  localparam logic [AW-1:0] C_STRIDE = AW'(H_RES);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_VB = 2'd1,
    S_FILL    = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t        state_q;
  logic [XW-1:0] x0_q;
  logic [XW-1:0] x1_q;
  logic [YW-1:0] y1_q;
  logic [CW-1:0] color_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic [AW-1:0] row_base_q;
  logic          last_q;
  logic          we_q;
  logic [AW-1:0] waddr_q;
  logic [CW-1:0] wdata_q;
  logic          done_q;
  logic          err_q;

  logic          w_cmd_bad;

  assign w_cmd_bad = (bus.cmd_x0 > bus.cmd_x1) || (bus.cmd_y0 > bus.cmd_y1) ||
                     (bus.cmd_x1 > C_X_LAST)   || (bus.cmd_y1 > C_Y_LAST);

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      x0_q       <= '0;
      x1_q       <= '0;
      y1_q       <= '0;
      color_q    <= '0;
      x_q        <= '0;
      y_q        <= '0;
      row_base_q <= '0;
      last_q     <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            if (w_cmd_bad) begin
              err_q <= 1'b1;
            end else begin
              // The only multiply: first row base; the fill loop just adds the stride.
              x0_q       <= bus.cmd_x0;
              x1_q       <= bus.cmd_x1;
              y1_q       <= bus.cmd_y1;
              color_q    <= bus.cmd_color;
              x_q        <= bus.cmd_x0;
              y_q        <= bus.cmd_y0;
              row_base_q <= AW'(bus.cmd_y0) * C_STRIDE;
              last_q     <= 1'b0;
              state_q    <= SYNC_VBLANK ? S_WAIT_VB : S_FILL;
            end
          end
        end
        S_WAIT_VB: begin
          if (bus.vblank) state_q <= S_FILL;
        end
        S_FILL: begin
          // last_q marks that (x1,y1) went out on the previous edge.
          if (last_q) begin
            last_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            we_q    <= 1'b1;
            waddr_q <= row_base_q + AW'(x_q);
            wdata_q <= color_q;
            if (x_q == x1_q) begin
              x_q        <= x0_q;
              y_q        <= y_q + 1'b1;
              row_base_q <= row_base_q + C_STRIDE;
              if (y_q == y1_q) last_q <= 1'b1;
            end else begin
              x_q <= x_q + 1'b1;
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.we        = we_q;
  assign bus.waddr     = waddr_q;
  assign bus.wdata     = wdata_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_vram_rect_fill.sv
`default_nettype none
// ============================================================================
// Module   : tb_vram_rect_fill
// Brief    : Self-checking bench for vram_rect_fill (immediate and vblank-gated
//            instances) against a raster-order write-list model.
// Revision : 1.0  initial release
// ============================================================================
module tb_vram_rect_fill;

  localparam int H_RES = 200;
  localparam int V_RES = 150;

  logic pclk = 1'b0;
  logic rst0;
  logic rst1;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 pclk = ~pclk;

  vram_rect_fill_if if0 ();
  vram_rect_fill_if if1 ();

  vram_rect_fill #(.H_RES(H_RES), .V_RES(V_RES), .AW(15), .XW(8), .YW(8), .CW(12),
                   .SYNC_VBLANK(1'b0)) u_dut0 (.pclk(pclk), .rst(rst0), .bus(if0));
  vram_rect_fill #(.H_RES(H_RES), .V_RES(V_RES), .AW(15), .XW(8), .YW(8), .CW(12),
                   .SYNC_VBLANK(1'b1)) u_dut1 (.pclk(pclk), .rst(rst1), .bus(if1));

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic drive0(input int x0, input int y0, input int x1, input int y1, input int col);
    if0.cmd_x0    = 8'(x0);
    if0.cmd_y0    = 8'(y0);
    if0.cmd_x1    = 8'(x1);
    if0.cmd_y1    = 8'(y1);
    if0.cmd_color = 12'(col);
  endtask

  // Raster-order reference write list for one rectangle.
  task automatic build_list(input int x0, input int y0, input int x1, input int y1,
                            inout int q[$]);
    for (int yy = y0; yy <= y1; yy++)
      for (int xx = x0; xx <= x1; xx++)
        q.push_back(yy * H_RES + xx);
  endtask

  task automatic fill0(input int x0, input int y0, input int x1, input int y1,
                       input int col, input string tag);
    int exp_q[$];
    int n, cyc, nw, first_cyc, done_cyc, n_bad, first_a, last_a;
    build_list(x0, y0, x1, y1, exp_q);
    n = exp_q.size();
    @(negedge pclk);
    check({tag, ".ready_pre"}, if0.cmd_ready, 1);
    drive0(x0, y0, x1, y1, col);
    if0.cmd_valid = 1'b1;
    @(negedge pclk);
    if0.cmd_valid = 1'b0;
    check({tag, ".busy"}, if0.busy, 1);
    cyc = 1; nw = 0; first_cyc = -1; done_cyc = -1; n_bad = 0; first_a = -1; last_a = -1;
    while (done_cyc < 0 && cyc < n + 10) begin
      @(negedge pclk);
      cyc++;
      if (if0.we) begin
        if (nw == 0) begin first_cyc = cyc; first_a = int'(if0.waddr); end
        if (nw >= n || int'(if0.waddr) != exp_q[nw] || int'(if0.wdata) != col ||
            cyc != first_cyc + nw) n_bad++;
        last_a = int'(if0.waddr);
        nw++;
      end
      if (if0.err) n_bad++;
      if (if0.done) begin
        done_cyc = cyc;
        if (if0.we || !if0.busy || if0.cmd_ready) n_bad++;
      end
    end
    check({tag, ".first_cyc"}, first_cyc, 2);
    check({tag, ".writes"}, nw, n);
    check({tag, ".seq_errs"}, n_bad, 0);
    check({tag, ".first_addr"}, first_a, exp_q[0]);
    check({tag, ".last_addr"}, last_a, exp_q[n-1]);
    check({tag, ".done_cyc"}, done_cyc, n + 2);
    @(negedge pclk);
    check({tag, ".ready_post"}, if0.cmd_ready, 1);
    check({tag, ".done_once"}, if0.done, 0);
  endtask

  task automatic reject0(input int x0, input int y0, input int x1, input int y1,
                         input string tag);
    @(negedge pclk);
    drive0(x0, y0, x1, y1, 12'hABC);
    if0.cmd_valid = 1'b1;
    @(negedge pclk);
    if0.cmd_valid = 1'b0;
    check({tag, ".err"}, if0.err, 1);
    check({tag, ".ready"}, if0.cmd_ready, 1);
    check({tag, ".we"}, if0.we, 0);
    @(negedge pclk);
    check({tag, ".err_pulse"}, if0.err, 0);
    check({tag, ".quiet"}, {if0.we, if0.busy, if0.cmd_ready}, 3'b001);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_bad, nw, cyc, r, first_b, n_done, last_a, na;
    int exp_q[$];
    rst0 = 1'b1; rst1 = 1'b1;
    if0.cmd_valid = 1'b0; if0.vblank = 1'b0; drive0(0, 0, 0, 0, 0);
    if1.cmd_valid = 1'b0; if1.vblank = 1'b0;
    if1.cmd_x0 = '0; if1.cmd_y0 = '0; if1.cmd_x1 = '0; if1.cmd_y1 = '0; if1.cmd_color = '0;
    repeat (2) @(negedge pclk);
    check("reset.outs", {if0.we, if0.done, if0.err, if0.busy}, 4'b0000);
    check("reset.waddr", if0.waddr, 0);
    check("reset.wdata", if0.wdata, 0);
    check("reset.ready", if0.cmd_ready, 1);
    rst0 = 1'b0; rst1 = 1'b0;

    fill0(5, 7, 5, 7, 12'hF00, "single");
    fill0(10, 0, 12, 1, 12'h0A5, "rect");
    fill0(199, 149, 199, 149, 12'h00F, "corner");
    fill0(0, 0, 199, 149, 12'h777, "full");
    reject0(0, 0, 200, 0, "rej_x1");
    reject0(9, 0, 8, 0, "rej_xswap");
    reject0(0, 0, 0, 150, "rej_y1");
    reject0(0, 5, 0, 4, "rej_yswap");

    for (int k = 0; k < 24; k++) begin
      int x0, y0, x1, y1, t, col;
      x0 = ($urandom_range(0, 1) == 1) ? int'($urandom_range(185, 199)) : int'($urandom_range(0, 199));
      y0 = ($urandom_range(0, 1) == 1) ? int'($urandom_range(140, 149)) : int'($urandom_range(0, 149));
      x1 = x0 + int'($urandom_range(0, 15));
      y1 = y0 + int'($urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0) begin t = x0; x0 = x1; x1 = t; end
      if ($urandom_range(0, 5) == 0) begin t = y0; y0 = y1; y1 = t; end
      col = int'($urandom_range(0, 4095));
      if (x0 <= x1 && y0 <= y1 && x1 < H_RES && y1 < V_RES)
        fill0(x0, y0, x1, y1, col, $sformatf("rnd%0d", k));
      else
        reject0(x0, y0, x1, y1, $sformatf("rnd%0d", k));
    end

    // Abort a full-screen fill with reset just after its 100th write.
    @(negedge pclk);
    drive0(0, 0, 199, 149, 12'h3C3);
    if0.cmd_valid = 1'b1;
    @(negedge pclk);
    if0.cmd_valid = 1'b0;
    nw = 0; cyc = 0; last_a = -1;
    while (nw < 100 && cyc < 300) begin
      @(negedge pclk);
      cyc++;
      if (if0.we) begin nw++; last_a = int'(if0.waddr); end
    end
    check("abort.reach100", nw, 100);
    check("abort.addr100", last_a, 99);
    rst0 = 1'b1;
    @(negedge pclk);
    check("abort.state", {if0.we, if0.done, if0.busy, if0.cmd_ready}, 4'b0001);
    rst0 = 1'b0;
    n_bad = 0;
    repeat (20) begin
      @(negedge pclk);
      if (if0.we || if0.done || if0.err || !if0.cmd_ready) n_bad++;
    end
    check("abort.quiet", n_bad, 0);
    fill0(0, 0, 0, 0, 12'h123, "after_rst");

    // Second command held valid during a fill; fields change right after the first accept.
    exp_q.delete();
    build_list(0, 0, 3, 0, exp_q);
    na = exp_q.size();
    build_list(196, 148, 199, 149, exp_q);
    @(negedge pclk);
    drive0(0, 0, 3, 0, 12'h111);
    if0.cmd_valid = 1'b1;
    @(negedge pclk);
    drive0(196, 148, 199, 149, 12'h222);
    cyc = 1; r = -1; first_b = -1; n_done = 0; nw = 0; n_bad = 0;
    while (n_done < 2 && cyc < 200) begin
      @(negedge pclk);
      cyc++;
      if (if0.we) begin
        if (nw == na) first_b = cyc;
        if (nw >= exp_q.size() || int'(if0.waddr) != exp_q[nw] ||
            int'(if0.wdata) != ((nw < na) ? 12'h111 : 12'h222)) n_bad++;
        nw++;
      end
      if (if0.done) n_done++;
      if (if0.err) n_bad++;
      if (r < 0 && if0.cmd_ready) r = cyc;
      else if (r >= 0 && cyc == r + 1) if0.cmd_valid = 1'b0;
    end
    if0.cmd_valid = 1'b0;
    check("hold.ready_cyc", r, na + 3);
    check("hold.first_b", first_b, r + 2);
    check("hold.writes", nw, exp_q.size());
    check("hold.seq_errs", n_bad, 0);
    check("hold.dones", n_done, 2);

    // Vblank-gated start; vblank drops mid-fill without stalling.
    exp_q.delete();
    build_list(20, 30, 29, 31, exp_q);
    @(negedge pclk);
    if1.cmd_x0 = 8'd20; if1.cmd_y0 = 8'd30; if1.cmd_x1 = 8'd29; if1.cmd_y1 = 8'd31;
    if1.cmd_color = 12'h5A5;
    if1.cmd_valid = 1'b1;
    @(negedge pclk);
    if1.cmd_valid = 1'b0;
    n_bad = 0;
    repeat (50) begin
      @(negedge pclk);
      if (if1.we || !if1.busy || if1.done || if1.cmd_ready) n_bad++;
    end
    check("vb.hold", n_bad, 0);
    if1.vblank = 1'b1;
    cyc = 0; nw = 0; n_bad = 0; first_b = -1; r = -1;
    while (r < 0 && cyc < 60) begin
      @(negedge pclk);
      cyc++;
      if (if1.we) begin
        if (nw == 0) first_b = cyc;
        if (nw >= exp_q.size() || int'(if1.waddr) != exp_q[nw] || int'(if1.wdata) != 12'h5A5 ||
            cyc != first_b + nw) n_bad++;
        nw++;
        if (nw == 3) if1.vblank = 1'b0;
      end
      if (if1.done) r = cyc;
    end
    check("vb.first_cyc", first_b, 2);
    check("vb.writes", nw, exp_q.size());
    check("vb.seq_errs", n_bad, 0);
    check("vb.done_cyc", r, exp_q.size() + 2);
    @(negedge pclk);
    check("vb.ready_post", if1.cmd_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
